// File: rtl/morse_element_classifier.sv
// morse_element_classifier: times key marks/spaces in Morse units
// and emits dot/dash symbols plus letter-end / word-end pulses.
// Ports: clk, resetn (async low), key_i (raw key, 1 = pressed);
//   sym_valid_o/sym_dash_o symbol event, letter_end_o, word_end_o
//   one-cycle gap events, busy_o high whenever not IDLE.
module morse_element_classifier #(
  parameter int UNIT_TICKS       = 5_000_000,
  parameter int DASH_UNITS       = 2,
  parameter int LETTER_GAP_UNITS = 2,
  parameter int WORD_GAP_UNITS   = 5,
  parameter int MAX_UNITS        = 15
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_i,
  output logic sym_valid_o,
  output logic sym_dash_o,
  output logic letter_end_o,
  output logic word_end_o,
  output logic busy_o
);

  localparam int TW = $clog2(UNIT_TICKS);
  localparam int UW = $clog2(MAX_UNITS + 1);

  localparam logic [TW-1:0] TLAST = TW'(UNIT_TICKS - 1);
  localparam logic [UW-1:0] UMAX  = UW'(MAX_UNITS);
  localparam logic [UW-1:0] UDASH = UW'(DASH_UNITS);
  localparam logic [UW-1:0] ULET  = UW'(LETTER_GAP_UNITS);
  localparam logic [UW-1:0] UWRD  = UW'(WORD_GAP_UNITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MARK    = 2'd1,
    SPACE_L = 2'd2,
    SPACE_W = 2'd3
  } state_t;

  logic          r_k1, r_k2, r_k3;
  logic          w_rise, w_fall, w_edge;
  logic          w_last, w_unit_tick;
  logic [TW-1:0] r_tick;
  logic [UW-1:0] r_units;
  logic [UW-1:0] w_units_eff;
  state_t        r_state, w_state_n;
  logic          w_sym_n, w_dash_n;
  logic          w_let_n, w_word_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_k1 <= 1'b0;
      r_k2 <= 1'b0;
      r_k3 <= 1'b0;
    end else begin
      r_k1 <= key_i;
      r_k2 <= r_k1;
      r_k3 <= r_k2;
    end
  end

  assign w_rise      = r_k2 & ~r_k3;
  assign w_fall      = ~r_k2 & r_k3;
  assign w_edge      = w_rise | w_fall;
  assign w_last      = (r_tick == TLAST);
  assign w_unit_tick = w_last & ~w_edge;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tick <= '0;
    end else if (w_edge || w_last) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_units <= '0;
    end else if (w_edge) begin
      r_units <= '0;
    end else if (w_unit_tick && r_units != UMAX) begin
      r_units <= r_units + UW'(1);
    end
  end

  // The fall cycle itself closes a unit when the prescaler sits on its
  // last tick; counting it makes a D-cycle mark worth floor(D/UNIT) units.
  assign w_units_eff = (w_last && r_units != UMAX) ?
                       r_units + UW'(1) : r_units;

  always_comb begin
    w_state_n = r_state;
    w_sym_n   = 1'b0;
    w_dash_n  = sym_dash_o;
    w_let_n   = 1'b0;
    w_word_n  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise) w_state_n = MARK;
      end
      MARK: begin
        if (w_fall) begin
          w_state_n = SPACE_L;
          w_sym_n   = 1'b1;
          w_dash_n  = (w_units_eff >= UDASH);
        end
      end
      SPACE_L: begin
        if (w_rise) begin
          w_state_n = MARK;
        end else if (r_units == ULET) begin
          w_state_n = SPACE_W;
          w_let_n   = 1'b1;
        end
      end
      SPACE_W: begin
        if (w_rise) begin
          w_state_n = MARK;
        end else if (r_units == UWRD) begin
          w_state_n = IDLE;
          w_word_n  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      sym_valid_o  <= 1'b0;
      sym_dash_o   <= 1'b0;
      letter_end_o <= 1'b0;
      word_end_o   <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      sym_valid_o  <= w_sym_n;
      sym_dash_o   <= w_dash_n;
      letter_end_o <= w_let_n;
      word_end_o   <= w_word_n;
    end
  end

  assign busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_morse_element_classifier.sv
// tb_morse_element_classifier: directed bench with an event scoreboard
// for morse_element_classifier at UNIT_TICKS=4.
module tb_morse_element_classifier;

  localparam int UT = 4;
  localparam int DU = 2;
  localparam int LG = 2;
  localparam int WG = 5;
  localparam int MU = 15;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic key_i = 1'b0;
  logic sym_valid_o, sym_dash_o;
  logic letter_end_o, word_end_o, busy_o;

  morse_element_classifier #(
    .UNIT_TICKS(UT),
    .DASH_UNITS(DU),
    .LETTER_GAP_UNITS(LG),
    .WORD_GAP_UNITS(WG),
    .MAX_UNITS(MU)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .key_i(key_i),
    .sym_valid_o(sym_valid_o),
    .sym_dash_o(sym_dash_o),
    .letter_end_o(letter_end_o),
    .word_end_o(word_end_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   kind;
    logic dash;
    int   at;
  } ev_t;

  ev_t q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // kind: 0 = symbol, 1 = letter end, 2 = word end
  always @(negedge clk) begin
    ev_t e;
    int  k;
    if (sym_valid_o || letter_end_o || word_end_o) begin
      chk("onehot", $countones({sym_valid_o, letter_end_o, word_end_o}), 1);
      k = sym_valid_o ? 0 : (letter_end_o ? 1 : 2);
      if (q.size() == 0) begin
        chk("unexpected_event", k, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("ev_kind", k, e.kind);
        chk("ev_cycle", cyc, e.at);
        if (e.kind == 0) chk("ev_dash", sym_dash_o, e.dash);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_key(int d);
    key_i = 1'b0;
    q.push_back('{kind: 0, dash: (d >= DU * UT), at: cyc + 3});
  endtask

  task automatic press(int d);
    key_i = 1'b1;
    tick(d);
    release_key(d);
  endtask

  task automatic space(int s);
    int n;
    n = cyc;
    if (s > LG * UT + 1)
      q.push_back('{kind: 1, dash: 1'b0, at: n + 3 + LG * UT + 1});
    if (s > WG * UT + 1)
      q.push_back('{kind: 2, dash: 1'b0, at: n + 3 + WG * UT + 1});
    tick(s);
  endtask

  initial begin
    int r;
    #1;
    chk("rst_sym", sym_valid_o, 0);
    chk("rst_dash", sym_dash_o, 0);
    chk("rst_let", letter_end_o, 0);
    chk("rst_word", word_end_o, 0);
    chk("rst_busy", busy_o, 0);
    tick(2);
    resetn = 1'b1;
    tick(3);

    press(4);
    space(30);
    chk("dot_idle", busy_o, 0);
    chk("dot_q", q.size(), 0);

    press(7);
    space(2);
    press(8);
    space(8);
    press(4);
    space(30);
    chk("gap_idle", busy_o, 0);
    chk("gap_q", q.size(), 0);

    key_i = 1'b1;
    tick(100);
    chk("stuck_units", dut.r_units, MU);
    chk("stuck_busy", busy_o, 1);
    tick(100);
    release_key(200);
    space(30);
    chk("stuck_dash_held", sym_dash_o, 1);
    chk("stuck_q", q.size(), 0);

    key_i = 1'b1;
    tick(5);
    chk("mm_busy", busy_o, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mm_sym", sym_valid_o, 0);
    chk("mm_dash", sym_dash_o, 0);
    chk("mm_let", letter_end_o, 0);
    chk("mm_word", word_end_o, 0);
    chk("mm_busy0", busy_o, 0);
    tick(7);
    key_i = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(20);
    chk("mm_idle", busy_o, 0);
    chk("mm_q", q.size(), 0);

    resetn = 1'b0;
    key_i = 1'b1;
    tick(2);
    resetn = 1'b1;
    r = cyc;
    tick(2);
    chk("held_busy_early", busy_o, 0);
    tick(1);
    chk("held_busy", busy_o, 1);
    tick(10);
    release_key(cyc - r);
    space(30);
    chk("held_idle", busy_o, 0);
    chk("held_q", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
